// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scanning N:1 channel multiplexer.
package mux_scan_pkg;

  localparam int unsigned MUX_SCAN_MIN_CH = 2;
  localparam int unsigned MUX_SCAN_MAX_CH = 32;

  typedef enum logic {MANUAL, SCAN} state_t;

  // Nearest enabled channel above cur (wrapping modulo n); cur itself if none.
  function automatic int unsigned next_ch(input int unsigned cur,
                                          input logic [MUX_SCAN_MAX_CH-1:0] mask,
                                          input int unsigned n);
    int unsigned res;
    int unsigned idx;
    res = cur;
    // Walk offsets high to low so the smallest enabled offset is kept.
    for (int unsigned i = MUX_SCAN_MAX_CH - 1; i > 0; i--) begin
      if (i < n) begin
        idx = (cur + i) % n;
        if (|(mask & (32'd1 << idx))) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_dwell_timer.sv
// Dwell counter for auto-scan; pulses advance_c in the cycle the dwell expires.
module mux_dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic               hold,
  input  logic [DWELL_W-1:0] dwell,
  output logic               advance_c
);

  logic [DWELL_W-1:0] cnt;

  // dwell is compared live, so a mid-dwell change applies at the next compare.
  assign advance_c = run && !hold && (cnt == dwell);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run && !hold) begin
      cnt <= advance_c ? '0 : cnt + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 mux with manual select and round-robin auto-scan.
// Optional MUX_SCAN_CH_MASK_EN adds a per-channel enable mask (ch_mask).
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int unsigned WIDTH   = 1,
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned DWELL_W = 8,
  localparam int unsigned SEL_W   = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*WIDTH-1:0]  din,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   auto_en,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic                   hold,
`ifdef MUX_SCAN_CH_MASK_EN
  input  logic [N_CH-1:0]        ch_mask,
`endif
  output logic [WIDTH-1:0]       dout,
  output logic [SEL_W-1:0]       ch_out,
  output logic                   ch_strobe
);

  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  if (N_CH < MUX_SCAN_MIN_CH) begin : g_bad_n_ch
    $error("mux_scan_n: N_CH must be at least %0d", MUX_SCAN_MIN_CH);
  end

  state_t              state;
  logic [N_CH-1:0]     en_mask;
  logic [SEL_SPAN-1:0] sel_mask;
  logic                run;
  logic                advance_c;
  logic [SEL_W-1:0]    ch_next;
  logic [WIDTH-1:0]    data_next;

`ifdef MUX_SCAN_CH_MASK_EN
  assign en_mask = ch_mask;
`else
  assign en_mask = '1;
`endif

  // Zero-extended to the full select range: out-of-range sel reads as disabled.
  assign sel_mask = SEL_SPAN'(en_mask);
  assign run      = (state == SCAN) && auto_en;

  mux_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == MANUAL),
    .run       (run),
    .hold      (hold),
    .dwell     (dwell),
    .advance_c (advance_c)
  );

  // Manual load (including the SCAN->MANUAL edge) wins over a dwell expiry.
  always_comb begin
    ch_next = ch_out;
    if (!auto_en) begin
      if (sel_mask[sel]) ch_next = sel;
    end else if (advance_c) begin
      ch_next = SEL_W'(next_ch(32'(ch_out), 32'(en_mask), N_CH));
    end
  end

  always_comb begin
    data_next = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (ch_next == SEL_W'(k)) data_next = din[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MANUAL;
      ch_out    <= '0;
      dout      <= '0;
      ch_strobe <= 1'b0;
    end else begin
      state     <= auto_en ? SCAN : MANUAL;
      ch_out    <= ch_next;
      dout      <= data_next;
      ch_strobe <= (ch_next != ch_out);
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Self-checking bench for mux_scan_n: a 4-channel and a 3-channel instance vs a behavioural model.
module tb_mux_scan_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        auto_en = 1'b0;
  logic [7:0]  dwell = 8'd0;
  logic        hold = 1'b0;
  logic [15:0] din4 = 16'd0;
  logic [11:0] din3 = 12'd0;
  logic [3:0]  mask4 = 4'hF;
  logic [3:0]  dout4, dout3;
  logic [1:0]  ch4, ch3;
  logic        stb4, stb3;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state, index 0 = 4-channel DUT, 1 = 3-channel DUT.
  bit m_scan[2];
  int m_cnt[2];
  int m_ch[2];
  int m_dout[2];
  bit m_strobe[2];

  always #5 clk = ~clk;

  mux_scan_n #(.WIDTH(4), .N_CH(4), .DWELL_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .sel(sel), .auto_en(auto_en),
    .dwell(dwell), .hold(hold),
`ifdef MUX_SCAN_CH_MASK_EN
    .ch_mask(mask4),
`endif
    .dout(dout4), .ch_out(ch4), .ch_strobe(stb4)
  );

  mux_scan_n #(.WIDTH(4), .N_CH(3), .DWELL_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .din(din3), .sel(sel), .auto_en(auto_en),
    .dwell(dwell), .hold(hold),
`ifdef MUX_SCAN_CH_MASK_EN
    .ch_mask(3'b111),
`endif
    .dout(dout3), .ch_out(ch3), .ch_strobe(stb3)
  );

  function automatic logic [31:0] obs_ch(input int d);
    return (d == 0) ? {30'd0, ch4} : {30'd0, ch3};
  endfunction
  function automatic logic [31:0] obs_dout(input int d);
    return (d == 0) ? {28'd0, dout4} : {28'd0, dout3};
  endfunction
  function automatic logic obs_stb(input int d);
    return (d == 0) ? stb4 : stb3;
  endfunction

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_step(input int d);
    int n;
    int old;
    logic [3:0]  msk;
    logic [15:0] dv;
    n   = (d == 0) ? 4 : 3;
    msk = (d == 0) ? mask4 : 4'b0111;
    dv  = (d == 0) ? din4 : {4'd0, din3};
    if (rst) begin
      m_scan[d] = 1'b0; m_cnt[d] = 0; m_ch[d] = 0; m_dout[d] = 0; m_strobe[d] = 1'b0;
    end else begin
      old = m_ch[d];
      if (!auto_en) begin
        m_scan[d] = 1'b0;
        m_cnt[d]  = 0;
        if (int'(sel) < n && msk[sel]) m_ch[d] = int'(sel);
      end else if (!m_scan[d]) begin
        m_scan[d] = 1'b1;
        m_cnt[d]  = 0;
      end else if (!hold) begin
        if (m_cnt[d] == int'(dwell)) begin
          m_cnt[d] = 0;
          for (int k = 1; k < n; k++) begin
            if (msk[2'((old + k) % n)]) begin
              m_ch[d] = (old + k) % n;
              break;
            end
          end
        end else begin
          m_cnt[d] = (m_cnt[d] + 1) % 256;
        end
      end
      m_dout[d]   = int'((dv >> (4 * m_ch[d])) & 16'hF);
      m_strobe[d] = (m_ch[d] != old);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; auto_en = 1'(($urandom)); sel = 2'($urandom); hold = 1'($urandom);
    for (int c = 0; c < 3; c++) begin
      din4 = 16'($urandom); din3 = 12'($urandom); dwell = 8'($urandom);
      drive_edge();
      n_tests++;
      if ({ch4, dout4, stb4, ch3, dout3, stb3} !== 14'd0) begin
        n_fail++;
        $display("FAIL reset: ch4=%0d dout4=%0d stb4=%0d ch3=%0d dout3=%0d stb3=%0d, required all 0",
                 ch4, dout4, stb4, ch3, dout3, stb3);
      end
    end
    rst = 1'b0; auto_en = 1'b0; sel = 2'd2; hold = 1'b0;
    din4 = 16'($urandom); din4[11:8] = 4'd1;
    din3 = 12'($urandom); din3[11:8] = 4'd1;
    drive_edge();
    n_tests++;
    if (ch4 !== 2'd2 || dout4 !== 4'd1 || stb4 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: ch=%0d dout=%0d stb=%0d, required ch=2 dout=1 stb=1", ch4, dout4, stb4);
    end
    drive_edge();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (obs_ch(d) !== m_ch[d] || obs_dout(d) !== m_dout[d] || obs_stb(d) !== m_strobe[d]) begin
        n_fail++;
        $display("FAIL reset_settle dut%0d: ch=%0d dout=%0d stb=%0d, required ch=%0d dout=%0d stb=%0d",
                 d, obs_ch(d), obs_dout(d), obs_stb(d), m_ch[d], m_dout[d], m_strobe[d]);
      end
    end
  endtask

  task automatic test_manual();
    int seq[4] = '{0, 1, 3, 3};
    int strobes = 0;
    auto_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(seq[i]); din4 = 16'($urandom); din3 = 12'($urandom);
      drive_edge();
      if (stb4) strobes++;
      n_tests++;
      if (ch4 !== 2'(seq[i])) begin
        n_fail++;
        $display("FAIL manual_step%0d: ch=%0d, required %0d", i, ch4, seq[i]);
      end
    end
    n_tests++;
    if (strobes != 3) begin
      n_fail++;
      $display("FAIL manual_strobes: got %0d pulses, required 3", strobes);
    end
    for (int c = 0; c < 20; c++) begin
      sel = 2'($urandom); hold = 1'($urandom); din4 = 16'($urandom); din3 = 12'($urandom);
      drive_edge();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_ch(d) !== m_ch[d] || obs_dout(d) !== m_dout[d] || obs_stb(d) !== m_strobe[d]) begin
          n_fail++;
          $display("FAIL manual_rand dut%0d: ch=%0d dout=%0d stb=%0d, required ch=%0d dout=%0d stb=%0d",
                   d, obs_ch(d), obs_dout(d), obs_stb(d), m_ch[d], m_dout[d], m_strobe[d]);
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_scan();
    int exp_ch[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int strobes = 0;
    auto_en = 1'b0; sel = 2'd0;
    drive_edge();
    auto_en = 1'b1; dwell = 8'd2; hold = 1'b0;
    for (int i = 0; i < 13; i++) begin
      din4 = 16'($urandom); din3 = 12'($urandom);
      drive_edge();
      if (stb4) strobes++;
      n_tests++;
      if (ch4 !== 2'(exp_ch[i])) begin
        n_fail++;
        $display("FAIL scan_seq%0d: ch=%0d, required %0d", i, ch4, exp_ch[i]);
      end
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_ch(d) !== m_ch[d] || obs_dout(d) !== m_dout[d] || obs_stb(d) !== m_strobe[d]) begin
          n_fail++;
          $display("FAIL scan_model dut%0d: ch=%0d dout=%0d stb=%0d, required ch=%0d dout=%0d stb=%0d",
                   d, obs_ch(d), obs_dout(d), obs_stb(d), m_ch[d], m_dout[d], m_strobe[d]);
        end
      end
    end
    n_tests++;
    if (strobes != 4) begin
      n_fail++;
      $display("FAIL scan_strobes: got %0d pulses, required 4", strobes);
    end
  endtask

  task automatic test_hold_mode();
    int held;
    held = m_ch[0];
    dwell = 8'd0; hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      din4 = 16'($urandom); din3 = 12'($urandom);
      drive_edge();
      n_tests++;
      if (ch4 !== 2'(held) || stb4 !== 1'b0 || dout4 !== 4'(m_dout[0])) begin
        n_fail++;
        $display("FAIL hold: ch=%0d stb=%0d dout=%0d, required ch=%0d stb=0 dout=%0d",
                 ch4, stb4, dout4, held, m_dout[0]);
      end
    end
    hold = 1'b0; auto_en = 1'b0; sel = 2'd1;
    drive_edge();
    n_tests++;
    if (ch4 !== 2'd1 || ch3 !== 2'd1) begin
      n_fail++;
      $display("FAIL scan_exit: ch4=%0d ch3=%0d, required 1", ch4, ch3);
    end
  endtask

  task automatic test_nch3_invalid();
    auto_en = 1'b0; sel = 2'd1;
    drive_edge();
    sel = 2'd3;
    for (int c = 0; c < 3; c++) begin
      din3 = 12'($urandom); din4 = 16'($urandom);
      drive_edge();
      n_tests++;
      if (ch3 !== 2'd1 || stb3 !== 1'b0 || dout3 !== din3[7:4]) begin
        n_fail++;
        $display("FAIL nch3_invalid_sel: ch=%0d stb=%0d dout=%0d, required ch=1 stb=0 dout=%0d",
                 ch3, stb3, dout3, din3[7:4]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    auto_en = 1'b1; dwell = 8'd0; hold = 1'b0;
    repeat (3) begin
      din4 = 16'($urandom | 32'h1111); din3 = 12'($urandom | 32'h111);
      drive_edge();
    end
    rst = 1'b1;
    drive_edge();
    n_tests++;
    if ({ch4, dout4, stb4, ch3, dout3, stb3} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_scan: ch4=%0d dout4=%0d stb4=%0d ch3=%0d dout3=%0d stb3=%0d, required all 0",
               ch4, dout4, stb4, ch3, dout3, stb3);
    end
    rst = 1'b0; auto_en = 1'b0;
  endtask

`ifdef MUX_SCAN_CH_MASK_EN
  task automatic test_mask();
    int exp_ch[4] = '{1, 3, 1, 3};
    mask4 = 4'hF; auto_en = 1'b0; sel = 2'd0; hold = 1'b0;
    drive_edge();
    mask4 = 4'b1010; auto_en = 1'b1; dwell = 8'd0;
    drive_edge();
    for (int i = 0; i < 4; i++) begin
      din4 = 16'($urandom);
      drive_edge();
      n_tests++;
      if (ch4 !== 2'(exp_ch[i]) || stb4 !== 1'b1) begin
        n_fail++;
        $display("FAIL mask_alt%0d: ch=%0d stb=%0d, required ch=%0d stb=1", i, ch4, stb4, exp_ch[i]);
      end
    end
    mask4 = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      drive_edge();
      n_tests++;
      if (ch4 !== 2'd3 || stb4 !== 1'b0) begin
        n_fail++;
        $display("FAIL mask_none: ch=%0d stb=%0d, required ch=3 stb=0", ch4, stb4);
      end
    end
    rst = 1'b1;
    drive_edge();
    n_tests++;
    if ({ch4, dout4, stb4} !== 7'd0) begin
      n_fail++;
      $display("FAIL mask_reset: ch=%0d dout=%0d stb=%0d, required all 0", ch4, dout4, stb4);
    end
    rst = 1'b0; auto_en = 1'b0; mask4 = 4'hF;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      sel   = 2'($urandom);
      dwell = 8'($urandom_range(0, 3));
      hold  = ($urandom_range(0, 3) == 0);
      din4  = 16'($urandom); din3 = 12'($urandom);
`ifdef MUX_SCAN_CH_MASK_EN
      if ($urandom_range(0, 9) == 0) mask4 = 4'($urandom);
`endif
      drive_edge();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (obs_ch(d) !== m_ch[d] || obs_dout(d) !== m_dout[d] || obs_stb(d) !== m_strobe[d]) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d: ch=%0d dout=%0d stb=%0d, required ch=%0d dout=%0d stb=%0d",
                   c, d, obs_ch(d), obs_dout(d), obs_stb(d), m_ch[d], m_dout[d], m_strobe[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_hold_mode();
    test_nch3_invalid();
    test_reset_mid_scan();
`ifdef MUX_SCAN_CH_MASK_EN
    test_mask();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
